// File: rtl/dcf77_frame_decoder.sv
// rtl/dcf77_frame_decoder.sv - DCF77 pulse-train decoder with frame checks and multi-frame confirmation
module dcf77_frame_decoder #(
    parameter int CLK_HZ           = 500,
    parameter bit PULSE_ACTIVE_LOW = 1'b1,
    parameter int CONFIRM_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        dcf_in,
    output logic [36:0] time_out,
    output logic        data_valid,
    output logic        frame_strobe,
    output logic        bit_strobe,
    output logic        bit_value,
    output logic [5:0]  err_flags
);

    localparam int T_MIN   = CLK_HZ * 40 / 1000;
    localparam int T_SPLIT = CLK_HZ * 150 / 1000;
    localparam int T_MAX   = CLK_HZ * 250 / 1000;
    localparam int T_GAP   = CLK_HZ * 1500 / 1000;
    localparam int T_LOST  = CLK_HZ * 2500 / 1000;
    localparam int PW      = $clog2(T_MAX + 2);
    localparam int PERW    = $clog2(T_LOST + 1);

    localparam logic [PW-1:0]   PULSE_SAT = PW'(T_MAX + 1);
    localparam logic [PERW-1:0] PER_SAT   = PERW'(T_LOST);
    localparam logic [PERW-1:0] PER_PRE   = PERW'(T_LOST - 1);
    localparam logic [2:0]      CONF      = 3'(CONFIRM_FRAMES);

    typedef enum logic {HUNT, RECEIVE} state_t;

    state_t           state;
    logic             sync1, sync2, act_d;
    logic             act, lead, trail, mark, loss;
    logic [PW-1:0]    pulse_cnt;
    logic [PERW-1:0]  period_cnt;
    logic             width_ok, decoded;
    logic [58:0]      sr;
    logic [5:0]       bit_cnt;
    logic             pulse_err;
    logic [2:0]       streak;
    logic [6:0]       prev_min;
    logic [6:0]       next_min;
    logic             digit_ok, range_ok, parity_ok;
    logic [3:0]       frame_flags;
    logic             frame_good, consec_ok;
    logic [2:0]       streak_new;
    logic [36:0]      time_new;
    logic             unused_bits;

    // Bits carrying weather/announcement data are received but never decoded
    assign unused_bits = ^{sr[16:0], sr[19]};

    // Polarity-corrected level and edge classification
    assign act   = PULSE_ACTIVE_LOW ? ~sync2 : sync2;
    assign lead  = act & ~act_d;
    assign trail = ~act & act_d;
    assign mark  = lead && (period_cnt >= PERW'(T_GAP));
    // A leading edge restarts the period, so it pre-empts a loss timeout
    assign loss  = ~lead && (period_cnt == PER_PRE);

    assign width_ok = (pulse_cnt >= PW'(T_MIN)) && (pulse_cnt <= PW'(T_MAX));
    assign decoded  = (pulse_cnt >= PW'(T_SPLIT));

    // Two-flop synchroniser plus edge-detect register, reset to the idle level
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1 <= PULSE_ACTIVE_LOW;
            sync2 <= PULSE_ACTIVE_LOW;
            act_d <= 1'b0;
        end else begin
            sync1 <= dcf_in;
            sync2 <= sync1;
            act_d <= act;
        end
    end

    // Saturating pulse-width and leading-edge period counters
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pulse_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            if (lead)
                pulse_cnt <= PW'(1);
            else if (act)
                pulse_cnt <= (pulse_cnt == PULSE_SAT) ? PULSE_SAT : pulse_cnt + PW'(1);
            else
                pulse_cnt <= '0;

            if (lead)
                period_cnt <= PERW'(1);
            else if (period_cnt != PER_SAT)
                period_cnt <= period_cnt + PERW'(1);
        end
    end

    // Frame plausibility checks and BCD minute successor of the previous frame
    always_comb begin
        digit_ok = (sr[24:21] <= 4'd9) && (sr[32:29] <= 4'd9) && (sr[39:36] <= 4'd9) &&
                   (sr[48:45] <= 4'd9) && (sr[53:50] <= 4'd9) && (sr[57:54] <= 4'd9);
        range_ok = digit_ok &&
                   ({1'b0, sr[27:21]} <= 8'h59) &&
                   ({2'b0, sr[34:29]} <= 8'h23) &&
                   (sr[41:36] != 6'd0) && ({2'b0, sr[41:36]} <= 8'h31) &&
                   (sr[44:42] != 3'd0) &&
                   (sr[49:45] != 5'd0) && ({3'b0, sr[49:45]} <= 8'h12);
        parity_ok = sr[20] && !(^sr[28:21]) && !(^sr[35:29]) && !(^sr[58:36]);
        frame_flags = {~range_ok, ~parity_ok, (bit_cnt != 6'd59), pulse_err};
        frame_good  = (frame_flags == 4'd0);

        if (prev_min[3:0] == 4'd9) begin
            if (prev_min[6:4] == 3'd5)
                next_min = 7'h00;
            else
                next_min = {prev_min[6:4] + 3'd1, 4'd0};
        end else begin
            next_min = {prev_min[6:4], prev_min[3:0] + 4'd1};
        end
        consec_ok = (streak != 3'd0) && (sr[27:21] == next_min);

        if (streak == 3'd0)
            streak_new = 3'd1;
        else if (consec_ok)
            streak_new = (streak == CONF) ? CONF : streak + 3'd1;
        else
            streak_new = 3'd1;

        time_new = {sr[18], sr[17], sr[57:50], sr[49:45], sr[44:42], sr[41:36], sr[34:29], sr[27:21]};
    end

    // Decoder FSM: bit capture, minute-mark evaluation, streak and loss handling
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state        <= HUNT;
            sr           <= '0;
            bit_cnt      <= '0;
            pulse_err    <= 1'b0;
            streak       <= '0;
            prev_min     <= '0;
            time_out     <= '0;
            data_valid   <= 1'b0;
            frame_strobe <= 1'b0;
            bit_strobe   <= 1'b0;
            bit_value    <= 1'b0;
            err_flags    <= '0;
        end else begin
            frame_strobe <= 1'b0;
            bit_strobe   <= 1'b0;

            if (mark) begin
                frame_strobe <= 1'b1;
                if (state == RECEIVE) begin
                    err_flags <= {1'b0, frame_good && (streak != 3'd0) && !consec_ok, frame_flags};
                    if (frame_good) begin
                        streak   <= streak_new;
                        prev_min <= sr[27:21];
                        if (streak_new == CONF) begin
                            time_out   <= time_new;
                            data_valid <= 1'b1;
                        end else begin
                            data_valid <= data_valid && consec_ok;
                        end
                    end else begin
                        streak     <= '0;
                        data_valid <= 1'b0;
                    end
                end
                state     <= RECEIVE;
                bit_cnt   <= '0;
                pulse_err <= 1'b0;
            end else if (trail) begin
                if (!width_ok) begin
                    pulse_err <= 1'b1;
                end else begin
                    bit_value  <= decoded;
                    bit_strobe <= 1'b1;
                    if (bit_cnt < 6'd59)
                        sr[bit_cnt] <= decoded;
                    if (bit_cnt != 6'd60)
                        bit_cnt <= bit_cnt + 6'd1;
                end
            end

            if (loss) begin
                state      <= HUNT;
                data_valid <= 1'b0;
                streak     <= '0;
                err_flags  <= 6'b100000;
            end
        end
    end

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// tb/tb_dcf77_frame_decoder.sv - directed self-checking bench for dcf77_frame_decoder
module tb_dcf77_frame_decoder;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        dcf_in = 1'b1;
    logic        dcf_inv;
    logic [36:0] time_out, time2;
    logic        data_valid, dv2, frame_strobe, fs2, bit_strobe, bs2, bit_value, bv2;
    logic [5:0]  err_flags, err2;

    int errors = 0;
    int checks = 0;
    int bs_total = 0;
    int fs_total = 0;
    logic bs_log [0:2047];

    logic [58:0] f34, f35, f36b, f40, f41, f42, f43, f44, f59, f00;
    logic [36:0] t35, t41, t00;

    assign dcf_inv = ~dcf_in;

    always #5 clk = ~clk;

    dcf77_frame_decoder dut (
        .clk(clk), .nReset(nReset), .dcf_in(dcf_in),
        .time_out(time_out), .data_valid(data_valid), .frame_strobe(frame_strobe),
        .bit_strobe(bit_strobe), .bit_value(bit_value), .err_flags(err_flags)
    );

    dcf77_frame_decoder #(.PULSE_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .nReset(nReset), .dcf_in(dcf_inv),
        .time_out(time2), .data_valid(dv2), .frame_strobe(fs2),
        .bit_strobe(bs2), .bit_value(bv2), .err_flags(err2)
    );

    always @(negedge clk) begin
        if (bit_strobe && bs_total < 2048) begin
            bs_log[bs_total] = bit_value;
            bs_total = bs_total + 1;
        end
        if (frame_strobe)
            fs_total = fs_total + 1;
    end

    function automatic logic [58:0] make_frame(input logic [7:0] mn, input logic [7:0] hr,
                                               input logic [7:0] dy, input logic [2:0] wd,
                                               input logic [7:0] mo, input logic [7:0] yr);
        logic [58:0] f;
        f = '0;
        f[17] = 1'b1;
        f[20] = 1'b1;
        f[27:21] = mn[6:0];
        f[28] = ^mn[6:0];
        f[34:29] = hr[5:0];
        f[35] = ^hr[5:0];
        f[41:36] = dy[5:0];
        f[44:42] = wd;
        f[49:45] = mo[4:0];
        f[57:50] = yr;
        f[58] = ^f[57:36];
        return f;
    endfunction

    function automatic logic [36:0] exp_time(input logic [7:0] mn, input logic [7:0] hr);
        return {2'b01, 8'h18, 5'h07, 3'd4, 6'h19, hr[5:0], mn[6:0]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int w);
        dcf_in = 1'b0;
        cyc(w);
        dcf_in = 1'b1;
    endtask

    task automatic send_frame(input logic [58:0] f, input int nbits, input int w0, input int w1,
                              input int glitch_at, input int glitch_w);
        int w;
        for (int i = 0; i < nbits; i++) begin
            w = f[i] ? w1 : w0;
            pulse(w);
            if (i == nbits - 1) begin
                cyc(800 - w);
            end else begin
                cyc(20);
                if (i == glitch_at) begin
                    pulse(glitch_w);
                    cyc(20);
                end
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        cyc(3);
        checks++;
        if ({time_out, data_valid, frame_strobe, bit_strobe, bit_value, err_flags} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: time=%h dv=%0b fs=%0b bs=%0b bv=%0b err=%b expected all 0",
                     time_out, data_valid, frame_strobe, bit_strobe, bit_value, err_flags);
        end
        checks++;
        if ({time2, dv2, fs2, bs2, bv2, err2} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs_hi: time=%h dv=%0b err=%b expected all 0", time2, dv2, err2);
        end
        nReset = 1'b1;
        cyc(800);
        checks++;
        if (fs_total !== 0 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: frames=%0d err=%b expected 0 frames err=000000", fs_total, err_flags);
        end
    endtask

    task automatic test_confirm();
        int base;
        int bad;
        base = bs_total;
        send_frame(f34, 59, 30, 80, -1, 0);
        checks++;
        if (fs_total !== 1) begin
            errors++;
            $display("FAIL confirm_mark_count: frames=%0d expected 1", fs_total);
        end
        checks++;
        if (bs_total - base !== 59) begin
            errors++;
            $display("FAIL confirm_bit_count: bits=%0d expected 59", bs_total - base);
        end
        bad = 0;
        for (int i = 0; i < 59; i++)
            if (bs_log[base + i] !== f34[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL confirm_bit_values: %0d wrong bits expected 0", bad);
        end
        send_frame(f35, 59, 30, 80, -1, 0);
        checks++;
        if (data_valid !== 1'b0 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL confirm_first_frame: dv=%0b err=%b expected dv=0 err=000000", data_valid, err_flags);
        end
    endtask

    task automatic test_parity();
        send_frame(f36b, 59, 30, 80, -1, 0);
        checks++;
        if (data_valid !== 1'b1 || time_out !== t35 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL confirm_second_frame: dv=%0b time=%h err=%b expected dv=1 time=%h err=000000",
                     data_valid, time_out, err_flags, t35);
        end
        checks++;
        if (dv2 !== 1'b1 || time2 !== t35) begin
            errors++;
            $display("FAIL confirm_active_high: dv=%0b time=%h expected dv=1 time=%h", dv2, time2, t35);
        end
        send_frame(f34, 59, 30, 80, -1, 0);
        checks++;
        if (err_flags !== 6'b000100 || data_valid !== 1'b0 || time_out !== t35) begin
            errors++;
            $display("FAIL parity_error: err=%b dv=%0b time=%h expected err=000100 dv=0 time=%h",
                     err_flags, data_valid, time_out, t35);
        end
    endtask

    task automatic test_nonconsec();
        int base;
        int bad;
        send_frame(f40, 59, 30, 80, -1, 0);
        checks++;
        if (err_flags !== 6'd0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL nonconsec_restart: err=%b dv=%0b expected err=000000 dv=0", err_flags, data_valid);
        end
        base = bs_total;
        send_frame(f41, 59, 74, 75, -1, 0);
        checks++;
        if (err_flags !== 6'b010000 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL nonconsec_flag: err=%b dv=%0b expected err=010000 dv=0", err_flags, data_valid);
        end
        bad = 0;
        for (int i = 0; i < 59; i++)
            if (bs_log[base + i] !== f41[i]) bad++;
        checks++;
        if (bs_total - base !== 59 || bad !== 0) begin
            errors++;
            $display("FAIL width_74_75: bits=%0d wrong=%0d expected 59 bits 0 wrong", bs_total - base, bad);
        end
    endtask

    task automatic test_pulse_width();
        send_frame(f42, 59, 30, 80, 10, 19);
        checks++;
        if (data_valid !== 1'b1 || time_out !== t41 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL nonconsec_recover: dv=%0b time=%h err=%b expected dv=1 time=%h err=000000",
                     data_valid, time_out, err_flags, t41);
        end
        send_frame(f43, 59, 30, 80, 10, 126);
        checks++;
        if (err_flags !== 6'b000001 || data_valid !== 1'b0 || time_out !== t41) begin
            errors++;
            $display("FAIL width_19: err=%b dv=%0b time=%h expected err=000001 dv=0 time=%h",
                     err_flags, data_valid, time_out, t41);
        end
        send_frame(f44, 58, 30, 80, -1, 0);
        checks++;
        if (err_flags !== 6'b000001 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL width_126: err=%b dv=%0b expected err=000001 dv=0", err_flags, data_valid);
        end
    endtask

    task automatic test_wrap();
        send_frame(f59, 59, 30, 80, -1, 0);
        checks++;
        if (err_flags !== 6'b000010 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL bit_count_58: err=%b dv=%0b expected err=000010 dv=0", err_flags, data_valid);
        end
        send_frame(f00, 59, 30, 80, -1, 0);
        checks++;
        if (err2 !== 6'd0 || dv2 !== 1'b0 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL wrap_first: err=%b err_hi=%b dv_hi=%0b expected 000000 000000 0", err_flags, err2, dv2);
        end
        pulse(30);
        cyc(20);
        checks++;
        if (data_valid !== 1'b1 || time_out !== t00 || err_flags !== 6'd0) begin
            errors++;
            $display("FAIL wrap_confirm: dv=%0b time=%h err=%b expected dv=1 time=%h err=000000",
                     data_valid, time_out, err_flags, t00);
        end
        checks++;
        if (dv2 !== 1'b1 || time2 !== t00 || err2 !== 6'd0) begin
            errors++;
            $display("FAIL wrap_confirm_hi: dv=%0b time=%h err=%b expected dv=1 time=%h err=000000",
                     dv2, time2, err2, t00);
        end
    endtask

    task automatic test_loss();
        cyc(1300);
        checks++;
        if (data_valid !== 1'b0 || err_flags !== 6'b100000) begin
            errors++;
            $display("FAIL loss: dv=%0b err=%b expected dv=0 err=100000", data_valid, err_flags);
        end
        checks++;
        if (dv2 !== 1'b0 || err2 !== 6'b100000) begin
            errors++;
            $display("FAIL loss_hi: dv=%0b err=%b expected dv=0 err=100000", dv2, err2);
        end
    endtask

    task automatic test_reset_mid();
        int bs_before;
        int fs_before;
        pulse(80);
        cyc(20);
        checks++;
        if (bit_value !== 1'b1 || err_flags !== 6'b100000) begin
            errors++;
            $display("FAIL pre_reset_state: bv=%0b err=%b expected bv=1 err=100000", bit_value, err_flags);
        end
        dcf_in = 1'b0;
        cyc(10);
        #3;
        nReset = 1'b0;
        #1;
        checks++;
        if ({time_out, data_valid, frame_strobe, bit_strobe, bit_value, err_flags} !== 43'd0) begin
            errors++;
            $display("FAIL async_reset: time=%h dv=%0b bv=%0b err=%b expected all 0",
                     time_out, data_valid, bit_value, err_flags);
        end
        checks++;
        if ({time2, dv2, fs2, bs2, bv2, err2} !== 43'd0) begin
            errors++;
            $display("FAIL async_reset_hi: time=%h dv=%0b err=%b expected all 0", time2, dv2, err2);
        end
        dcf_in = 1'b1;
        cyc(2);
        nReset = 1'b1;
        bs_before = bs_total;
        fs_before = fs_total;
        cyc(20);
        pulse(30);
        cyc(20);
        checks++;
        if (bs_total - bs_before !== 1 || fs_total !== fs_before || bit_value !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_no_mark: bits=%0d frames=%0d bv=%0b expected 1 0 0",
                     bs_total - bs_before, fs_total - fs_before, bit_value);
        end
    endtask

    initial begin
        f34  = make_frame(8'h34, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f35  = make_frame(8'h35, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f36b = make_frame(8'h36, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18) ^ (59'd1 << 22);
        f40  = make_frame(8'h40, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f41  = make_frame(8'h41, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f42  = make_frame(8'h42, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f43  = make_frame(8'h43, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f44  = make_frame(8'h44, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f59  = make_frame(8'h59, 8'h12, 8'h19, 3'd4, 8'h07, 8'h18);
        f00  = make_frame(8'h00, 8'h13, 8'h19, 3'd4, 8'h07, 8'h18);
        t35  = exp_time(8'h35, 8'h12);
        t41  = exp_time(8'h41, 8'h12);
        t00  = exp_time(8'h00, 8'h13);

        @(posedge clk);
        #1;
        test_reset();
        test_confirm();
        test_parity();
        test_nonconsec();
        test_pulse_width();
        test_wrap();
        test_loss();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
